// File: rtl/mem_access_stage.sv
// RV32 load/store stage: splits each access into BUS_BYTES-wide request/ack beats,
// stalls the pipeline until the last beat, then extends load data for writeback.
module mem_access_stage #(
  parameter int XLEN      = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   memRead_in,
  input  logic                   memWrite_in,
  input  logic [2:0]             memOp_in,
  input  logic [XLEN-1:0]        memAddr_in,
  input  logic [XLEN-1:0]        storeData_in,
  input  logic                   rdE_in,
  input  logic [4:0]             rdIdx_in,
  input  logic [XLEN-1:0]        rdData_in,
  output logic                   rdE_out,
  output logic [4:0]             rdIdx_out,
  output logic [XLEN-1:0]        rdData_out,
  output logic                   memStall_out,
  output logic                   memReq_out,
  output logic                   memWe_out,
  output logic [XLEN-1:0]        memAddr_out,
  output logic [8*BUS_BYTES-1:0] memWData_out,
  output logic [BUS_BYTES-1:0]   memBe_out,
  input  logic [8*BUS_BYTES-1:0] memRData_in,
  input  logic                   memAck_in
);
  localparam int BW = 8 * BUS_BYTES;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        nbeats_q, nbeats_d;
  logic [2:0]        beat_q, beat_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [XLEN-1:0]   maddr_q, maddr_d;
  logic [BW-1:0]     wdata_q, wdata_d;
  logic [BUS_BYTES-1:0] be_q, be_d;

  logic       access_in;
  logic [2:0] size_in;
  logic [2:0] nbeats_in;
  logic [2:0] beat_n;

  function automatic logic [2:0] size_of(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [BUS_BYTES-1:0] be_of(input logic [2:0] k, input logic [2:0] sz);
    logic [BUS_BYTES-1:0] be;
    for (int j = 0; j < BUS_BYTES; j++) be[j] = (int'(k) * BUS_BYTES + j) < int'(sz);
    return be;
  endfunction

  function automatic logic [BW-1:0] lanes_of(input logic [XLEN-1:0] data, input logic [2:0] k);
    logic [XLEN-1:0] sh;
    sh = data >> (int'(k) * BW);
    return sh[BW-1:0];
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] op);
    case (op)
      3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign access_in = memRead_in | memWrite_in;
  assign size_in   = size_of(memOp_in);
  assign nbeats_in = 3'((int'(size_in) + BUS_BYTES - 1) / BUS_BYTES);
  assign beat_n    = beat_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    op_d     = op_q;
    size_d   = size_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    asm_d    = asm_q;
    req_d    = req_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    case (state_q)
      IDLE: begin
        if (access_in) begin
          state_d  = BUSY;
          we_d     = memWrite_in;
          op_d     = memOp_in;
          size_d   = size_in;
          nbeats_d = nbeats_in;
          beat_d   = 3'd0;
          addr_d   = memAddr_in;
          sdata_d  = storeData_in;
          asm_d    = '0;
          req_d    = 1'b1;
          mwe_d    = memWrite_in;
          maddr_d  = memAddr_in;
          wdata_d  = lanes_of(storeData_in, 3'd0);
          be_d     = be_of(3'd0, size_in);
        end
      end
      BUSY: begin
        if (memAck_in) begin
          // Read lanes land at the beat's byte offset; bytes past XLEN are dropped.
          for (int j = 0; j < BUS_BYTES; j++) begin
            if (int'(beat_q) * BUS_BYTES + j < XLEN / 8)
              asm_d[(int'(beat_q) * BUS_BYTES + j) * 8 +: 8] = memRData_in[j * 8 +: 8];
          end
          if (beat_q == nbeats_q - 3'd1) begin
            state_d = DONE;
            req_d   = 1'b0;
          end else begin
            beat_d  = beat_n;
            maddr_d = addr_q + XLEN'(int'(beat_n) * BUS_BYTES);
            wdata_d = lanes_of(sdata_q, beat_n);
            be_d    = be_of(beat_n, size_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      op_q     <= '0;
      size_q   <= '0;
      nbeats_q <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      asm_q    <= '0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      op_q     <= op_d;
      size_q   <= size_d;
      nbeats_q <= nbeats_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      asm_q    <= asm_d;
      req_q    <= req_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  // Writeback fields pass through except for a completing load; all forced low in reset.
  always_comb begin
    rdE_out      = rdE_in;
    rdIdx_out    = rdIdx_in;
    rdData_out   = rdData_in;
    memStall_out = 1'b0;
    if (rst_in) begin
      rdE_out    = 1'b0;
      rdIdx_out  = '0;
      rdData_out = '0;
    end else begin
      case (state_q)
        IDLE:    memStall_out = access_in;
        BUSY:    memStall_out = 1'b1;
        default: if (!we_q) rdData_out = extend(asm_q, op_q);
      endcase
    end
  end

  assign memReq_out   = req_q;
  assign memWe_out    = mwe_q;
  assign memAddr_out  = maddr_q;
  assign memWData_out = wdata_q;
  assign memBe_out    = be_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: byte-wide instance with a wait-state memory
// responder, plus a word-wide instance driven by hand for the store case.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Byte-bus instance
  logic        rd1 = 0, wr1 = 0, rde_i1 = 0, ack1 = 0;
  logic [2:0]  op1 = 0;
  logic [31:0] addr1 = 0, sd1 = 0, rdd_i1 = 0;
  logic [4:0]  idx_i1 = 0;
  logic [7:0]  rdata1 = 0;
  logic        rde_o1, stall1, req1, we1;
  logic [4:0]  idx_o1;
  logic [31:0] rdd_o1, maddr1;
  logic [7:0]  wdata1;
  logic [0:0]  be1;

  mem_access_stage #(.XLEN(32), .BUS_BYTES(1)) u1 (
    .clk_in(clk), .rst_in(rst), .memRead_in(rd1), .memWrite_in(wr1), .memOp_in(op1),
    .memAddr_in(addr1), .storeData_in(sd1), .rdE_in(rde_i1), .rdIdx_in(idx_i1),
    .rdData_in(rdd_i1), .rdE_out(rde_o1), .rdIdx_out(idx_o1), .rdData_out(rdd_o1),
    .memStall_out(stall1), .memReq_out(req1), .memWe_out(we1), .memAddr_out(maddr1),
    .memWData_out(wdata1), .memBe_out(be1), .memRData_in(rdata1), .memAck_in(ack1)
  );

  // Word-bus instance
  logic        rd4 = 0, wr4 = 0, rde_i4 = 0, ack4 = 0;
  logic [2:0]  op4 = 0;
  logic [31:0] addr4 = 0, sd4 = 0, rdd_i4 = 0, rdata4 = 0;
  logic [4:0]  idx_i4 = 0;
  logic        rde_o4, stall4, req4, we4;
  logic [4:0]  idx_o4;
  logic [31:0] rdd_o4, maddr4, wdata4;
  logic [3:0]  be4;

  mem_access_stage #(.XLEN(32), .BUS_BYTES(4)) u4 (
    .clk_in(clk), .rst_in(rst), .memRead_in(rd4), .memWrite_in(wr4), .memOp_in(op4),
    .memAddr_in(addr4), .storeData_in(sd4), .rdE_in(rde_i4), .rdIdx_in(idx_i4),
    .rdData_in(rdd_i4), .rdE_out(rde_o4), .rdIdx_out(idx_o4), .rdData_out(rdd_o4),
    .memStall_out(stall4), .memReq_out(req4), .memWe_out(we4), .memAddr_out(maddr4),
    .memWData_out(wdata4), .memBe_out(be4), .memRData_in(rdata4), .memAck_in(ack4)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder for the byte-bus instance: withholds ack for wait_cfg cycles per beat.
  logic [7:0]  mem [0:4095];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          hold_err = 0;
  logic [31:0] held_addr = 0;
  logic [31:0] acked_q[$];

  always @(negedge clk) begin
    if (rst || !req1) begin
      ack1     = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wait_cnt > 0 && maddr1 != held_addr) hold_err++;
      held_addr = maddr1;
      if (wait_cnt >= wait_cfg) begin
        ack1     = 1'b1;
        rdata1   = mem[maddr1[11:0]];
        acked_q.push_back(maddr1);
        wait_cnt = 0;
      end else begin
        ack1 = 1'b0;
        wait_cnt++;
      end
    end
  end

  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int exp_stall);
    int   stall_cnt = 0;
    logic done = 1'b0;
    @(posedge clk); #1;
    acked_q.delete();
    rd1 = 1; wr1 = 0; op1 = op; addr1 = addr;
    rde_i1 = 1; idx_i1 = 5'd7; rdd_i1 = 32'hDEAD_BEEF;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall1) stall_cnt++;
      else begin
        done = 1'b1;
        chk({tag, "_data"}, rdd_o1, exp_data);
        chk({tag, "_idx"}, idx_o1, 5'd7);
        chk({tag, "_rde"}, rde_o1, 1'b1);
      end
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_stall"}, stall_cnt, exp_stall);
    @(posedge clk); #1;
    rd1 = 0; rde_i1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_req;
    mem[12'h100] = 8'h80;
    mem[12'h200] = 8'h78; mem[12'h201] = 8'h56; mem[12'h202] = 8'h34; mem[12'h203] = 8'h12;
    mem[12'h400] = 8'h34; mem[12'h401] = 8'hF2;

    // Reset values, with live inputs that must not leak through
    rd1 = 1; rde_i1 = 1; idx_i1 = 5'd3; rdd_i1 = 32'h55;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall1, 0);
    chk("rst_req", req1, 0);
    chk("rst_rde", rde_o1, 0);
    chk("rst_idx", idx_o1, 0);
    chk("rst_rdd", rdd_o1, 0);
    chk("rst_maddr", maddr1, 0);
    chk("rst_we", we1, 0);
    chk("rst_be4", be4, 0);
    chk("rst_wdata4", wdata4, 0);
    rd1 = 0; rde_i1 = 0;
    rst = 0;

    // ADD pass-through
    @(posedge clk); #1;
    rde_i1 = 1; idx_i1 = 5'd5; rdd_i1 = 32'h1234;
    #1;
    chk("add_rde", rde_o1, 1);
    chk("add_idx", idx_o1, 5);
    chk("add_rdd", rdd_o1, 32'h1234);
    chk("add_stall", stall1, 0);
    seen_req = 0;
    repeat (3) begin
      @(negedge clk);
      if (req1) seen_req++;
    end
    chk("add_noreq", seen_req, 0);
    rde_i1 = 0;

    // LB / LBU, immediate ack
    run_load("lb", 3'b000, 32'h100, 32'hFFFF_FF80, 2);
    chk("lb_nbeats", acked_q.size(), 1);
    if (acked_q.size() > 0) chk("lb_addr", acked_q[0], 32'h100);
    run_load("lbu", 3'b100, 32'h100, 32'h0000_0080, 2);

    // LW over four byte beats
    run_load("lw", 3'b010, 32'h200, 32'h1234_5678, 5);
    chk("lw_nbeats", acked_q.size(), 4);
    for (int k = 0; k < 4 && k < acked_q.size(); k++)
      chk($sformatf("lw_addr%0d", k), acked_q[k], 32'h200 + k);

    // LH with three wait states per beat
    wait_cfg = 3;
    hold_err = 0;
    run_load("lh_wait", 3'b001, 32'h400, 32'hFFFF_F234, 9);
    chk("lh_hold", hold_err, 0);
    chk("lh_nbeats", acked_q.size(), 2);
    wait_cfg = 0;

    // SH on the word bus, read and write both high: write wins
    @(posedge clk); #1;
    rd4 = 1; wr4 = 1; op4 = 3'b001; addr4 = 32'h300; sd4 = 32'hAABB_CCDD;
    rde_i4 = 1; idx_i4 = 5'd9; rdd_i4 = 32'h77;
    @(negedge clk);
    chk("sh_stall0", stall4, 1);
    chk("sh_req0", req4, 0);
    @(posedge clk); @(negedge clk);
    chk("sh_req1", req4, 1);
    chk("sh_we", we4, 1);
    chk("sh_be", be4, 4'b0011);
    chk("sh_wdata", wdata4, 32'hAABB_CCDD);
    chk("sh_maddr", maddr4, 32'h300);
    ack4 = 1;
    @(posedge clk); @(negedge clk);
    ack4 = 0;
    chk("sh_stall2", stall4, 0);
    chk("sh_req2", req4, 0);
    chk("sh_rdd", rdd_o4, 32'h77);
    @(posedge clk); #1;
    rd4 = 0; wr4 = 0; rde_i4 = 0;

    // Reset in the middle of an LW
    @(posedge clk); #1;
    rd1 = 1; op1 = 3'b010; addr1 = 32'h200; rde_i1 = 1; idx_i1 = 5'd4; rdd_i1 = 32'h99;
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_req_before", req1, 1);
    rst = 1; #1;
    chk("mid_req", req1, 0);
    chk("mid_stall", stall1, 0);
    chk("mid_rde", rde_o1, 0);
    chk("mid_idx", idx_o1, 0);
    chk("mid_rdd", rdd_o1, 0);
    chk("mid_maddr", maddr1, 0);
    rd1 = 0; rde_i1 = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_stall", stall1, 0);
    chk("post_req", req1, 0);
    run_load("lw_again", 3'b010, 32'h200, 32'h1234_5678, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised successor to the pass-through memory stage. Sits between EX_MEM and MEM_WB and executes RV32 loads and stores over a narrow request/acknowledge memory port, splitting each access into bus beats of `BUS_BYTES` bytes. Non-memory instructions pass straight through combinationally. `memStall_out` holds the pipeline until the access completes; loads are sign- or zero-extended before writeback.

## Interface
- `XLEN`, 32, register/data width.
- `BUS_BYTES`, 1, bytes per memory beat. Legal values: 1, 2, 4.
- `clk_in`  in  1  clock, rising edge.
- `rst_in`  in  1  reset. Asynchronous and active-high.
- `memRead_in`  in  1  EX_MEM: instruction is a load.
- `memWrite_in`  in  1  EX_MEM: instruction is a store. Wins if both are high.
- `memOp_in`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes behave as W.
- `memAddr_in`  in  XLEN  byte address.
- `storeData_in`  in  XLEN  store data, low bytes used.
- `rdE_in`, `rdIdx_in`[4:0], `rdData_in`[XLEN-1:0]  in  EX_MEM writeback fields.
- `rdE_out`, `rdIdx_out`[4:0], `rdData_out`[XLEN-1:0]  out  to MEM_WB.
- `memStall_out`  out  1  stall request to the pipeline controller.
- `memReq_out`  out  1  memory request, registered.
- `memWe_out`  out  1  1 = write beat.
- `memAddr_out`  out  XLEN  beat address.
- `memWData_out`  out  8*BUS_BYTES  write lanes, little-endian.
- `memBe_out`  out  BUS_BYTES  byte enables, meaningful on writes.
- `memRData_in`  in  8*BUS_BYTES  read lanes.
- `memAck_in`  in  1  beat complete. Ignored while `memReq_out` = 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, no access** (`memRead_in` = `memWrite_in` = 0):
  - `rdE_out`, `rdIdx_out` and `rdData_out` equal their inputs combinationally.
  - `memStall_out` = 0.
- **IDLE, access present**:
  - `memStall_out` = 1 combinationally.
  - At the clock edge, latch operation, address, store data, size and beat count; go to BUSY.
  - Beat count N = ceil(size / BUS_BYTES), where size is 1, 2 or 4 bytes.
- **BUSY**:
  - `memReq_out` = 1 and `memStall_out` = 1.
  - For beat k: `memAddr_out` = latched address + k*BUS_BYTES.
  - Writes: `memWData_out` = store bytes [k*BUS_BYTES +: BUS_BYTES]. `memBe_out` bit j = 1 iff k*BUS_BYTES + j < size.
  - Request outputs stay stable until `memAck_in`.
  - On ack, read lanes are captured into an assembly register at byte offset k*BUS_BYTES, and k increments.
  - On the ack of beat N-1, go to DONE and drop `memReq_out` at that edge.
- **DONE**, one cycle:
  - `memStall_out` = 0 and `rdIdx_out` = `rdIdx_in`.
  - Loads: `rdE_out` = `rdE_in`; `rdData_out` = assembled data, sign-extended (B, H) or zero-extended (BU, HU); W is unchanged.
  - Stores: outputs pass through.
  - Go to IDLE unconditionally. EX_MEM still holds the same instruction this cycle, so no restart occurs.
- **Address arithmetic**: wraps modulo 2^XLEN. No alignment check; the memory side is responsible for alignment.
- **Reset**, asserted at any time including mid-access: FSM goes to IDLE and the beat counter clears immediately. The in-flight access is abandoned and no retry is made.

## Timing
- Reset values:
  - Outputs: all 0 — `rdE_out`, `rdIdx_out`, `rdData_out`, `memStall_out`, `memReq_out`, `memWe_out`, `memAddr_out`, `memWData_out`, `memBe_out`.
  - Internal: assembly register 0.
- Request path: `memReq_out`, `memWe_out`, `memAddr_out`, `memWData_out` and `memBe_out` are registered.
- Stall and writeback path: `memStall_out` and the three writeback outputs are combinational from state and inputs.
- Earliest ack is in the first cycle `memReq_out` is high. After an ack, the next beat's request appears the following cycle, and `memReq_out` may stay high across beats.
- Latency with ack in every request cycle: access at cycle 0 → BUSY on cycles 1..N → DONE on cycle N+1.
  - Stall is high for cycles 0..N (N+1 cycles).
  - Example: LW with BUS_BYTES=1 stalls 5 cycles.
- Wait states extend BUSY one cycle per non-ack cycle; all request outputs stay unchanged.

## Test plan
- **ADD pass-through**: `rdE_in`=1, `rdIdx_in`=5, `rdData_in`=0x1234 → same values out combinationally; `memStall_out`=0; `memReq_out` never rises.
- **LB, BUS_BYTES=1**: addr 0x100, memory byte 0x80, ack immediate.
  - `memAddr_out`=0x100 on cycle 1.
  - DONE on cycle 2 with `rdData_out`=0xFFFFFF80.
  - LBU at the same address gives 0x00000080.
- **LW, BUS_BYTES=1**: addr 0x200, bytes 0x78, 0x56, 0x34, 0x12.
  - Addresses 0x200..0x203 on cycles 1–4.
  - Stall high on cycles 0–4.
  - `rdData_out`=0x12345678 on cycle 5.
- **SH, BUS_BYTES=4**: addr 0x300, store 0xAABBCCDD → one beat: `memWe_out`=1, `memBe_out`=0011, `memWData_out` low half 0xCCDD; DONE on cycle 2.
- **Wait states**: LH with BUS_BYTES=1, ack withheld for 3 cycles per beat → address and request held steady while waiting; total stall 9 cycles; result correct.
- **Reset mid-access**: pulse `rst_in` during beat 2 of an LW →
  - `memReq_out`, `memStall_out` and the writeback outputs go to 0 immediately.
  - After release the FSM is in IDLE, and a new LW completes normally.
